i2c_target_regfile: RTL and testbench

//  I2C target (slave) responder with an internal 2^REG_AW x 8 register file.
//  It is the counterpart to the HDMI-transmitter I2C configuration master.
//  It serves two roles: an on-board loopback target and a simulation model of the HDMI transmitter's config port.
//  It decodes START/STOP, matches a 7-bit device address, takes a register pointer, and then writes or reads bytes.
//  The pointer auto-increments after every byte.

---
 rtl/i2c_target_regfile.sv | 156 +++++++++++++++
 tb/tb_i2c_target_regfile.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a 2^REG_AW x 8 register file, auto-incrementing pointer, no clock stretching
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         REG_AW   = 8,
  parameter int         FILT_LEN = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  input  logic [REG_AW-1:0] host_raddr,
  output logic [7:0]        host_rdata
);
  localparam int HW = FILT_LEN - 1;

  typedef enum logic [2:0] {IDLE, ADDR, PTR, WR, RD, IGNORE} state_t;

  state_t              st, nxt;
  logic [1:0]          scl_sy, sda_sy;
  logic [HW-1:0]       scl_h, sda_h;
  logic                scl_f, sda_f, scl_q, sda_q;
  logic                start, stop, rise, fall, hit, wr_en, mack;
  logic [3:0]          cnt;
  logic [7:0]          sr, tx, rd_byte;
  logic [REG_AW-1:0]   ptr;
  logic [7:0]          regs [2**REG_AW];

  assign rise       = scl_f & ~scl_q;
  assign fall       = ~scl_f & scl_q;
  assign start      = scl_f & scl_q & sda_q & ~sda_f;
  assign stop       = scl_f & scl_q & ~sda_q & sda_f;
  assign hit        = (sr[7:1] == DEV_ADDR) && (|sr[7:1]);
  assign wr_en      = (st == WR) && fall && (cnt == 4'd8);
  assign rd_byte    = regs[ptr];
  assign host_rdata = regs[host_raddr];

  // Synchronise both pins, then only accept a level after FILT_LEN equal samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_h  <= '1;
      sda_h  <= '1;
      scl_f  <= 1'b1;
      sda_f  <= 1'b1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
      scl_h  <= HW'({scl_h, scl_sy[1]});
      sda_h  <= HW'({sda_h, sda_sy[1]});
      scl_f  <= (&{scl_h, scl_sy[1]}) ? 1'b1 : (~|{scl_h, scl_sy[1]}) ? 1'b0 : scl_f;
      sda_f  <= (&{sda_h, sda_sy[1]}) ? 1'b1 : (~|{sda_h, sda_sy[1]}) ? 1'b0 : sda_f;
      scl_q  <= scl_f;
      sda_q  <= sda_f;
    end
  end

  // Protocol state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= nxt;
  end

  // Next state: STOP/START override everything, otherwise advance at byte/ack boundaries
  always_comb begin
    nxt = st;
    if (stop)
      nxt = IDLE;
    else if (start)
      nxt = ADDR;
    else if (fall && st == ADDR && cnt == 4'd8 && !hit)
      nxt = IGNORE;
    else if (fall && cnt == 4'd9)
      case (st)
        ADDR:    nxt = sr[0] ? RD : PTR;
        PTR:     nxt = WR;
        RD:      nxt = mack ? RD : IGNORE;
        default: nxt = st;
      endcase
  end

  // Bit counter, shifters, pointer, ACK/data drive; cnt 8 = ack slot pending, 9 = ack slot clocked
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      sr       <= '0;
      tx       <= '0;
      mack     <= 1'b0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start || stop) begin
        cnt    <= '0;
        sda_oe <= 1'b0;
        if (stop) busy <= 1'b0;
      end else if (rise && cnt < 4'd9) begin
        cnt <= cnt + 4'd1;
        if (cnt < 4'd8) sr <= {sr[6:0], sda_f};
        if (st == RD && cnt == 4'd8) begin
          mack <= ~sda_f;
          ptr  <= ptr + 1'b1;
        end
      end else if (fall && cnt == 4'd8) begin
        case (st)
          ADDR: begin
            sda_oe <= hit;
            busy   <= busy | hit;
          end
          PTR: begin
            ptr    <= REG_AW'(sr);
            sda_oe <= 1'b1;
          end
          WR: begin
            wr_valid <= 1'b1;
            wr_addr  <= ptr;
            wr_data  <= sr;
            ptr      <= ptr + 1'b1;
            sda_oe   <= 1'b1;
          end
          default: sda_oe <= 1'b0;
        endcase
      end else if (fall && cnt == 4'd9) begin
        cnt <= '0;
        if ((st == ADDR && sr[0]) || (st == RD && mack)) begin
          sda_oe <= ~rd_byte[7];
          tx     <= {rd_byte[6:0], 1'b0};
        end else begin
          sda_oe <= 1'b0;
        end
      end else if (fall && st == RD && cnt != 4'd0) begin
        sda_oe <= ~tx[7];
        tx     <= {tx[6:0], 1'b0};
      end
    end
  end

  // Register file; cleared by reset, written at the end of each WR data byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    else if (wr_en)
      regs[ptr] <= sr;
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed I2C master driving the target, checked with immediate assertions
module tb_i2c_target_regfile;
  localparam int Q = 10;

  logic       clk = 1'b0, rstn = 1'b0, scl = 1'b1, msda = 1'b1;
  logic [7:0] host_raddr = 8'h00;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, host_rdata;
  wire        sda_bus = msda & ~sda_oe;

  int total = 0, bad = 0;
  int oe_cnt = 0, busy_cnt = 0, wv_cnt = 0;
  logic [7:0] wa[$], wd[$];

  logic       a0, a1, a2, a3, b;
  logic [7:0] d1, d2;
  int         oe0, busy0, wv0;

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk(clk), .rstn(rstn), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .host_raddr(host_raddr), .host_rdata(host_rdata)
  );

  // Observe outputs mid-cycle: activity counters and a log of register writes
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (wr_valid === 1'b1) begin
      wv_cnt++;
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_c();
    msda = 1'b1; tick(Q); scl = 1'b1; tick(Q); msda = 1'b0; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    msda = 1'b0; tick(Q); scl = 1'b1; tick(Q); msda = 1'b1; tick(2*Q);
  endtask

  // g=1: short inverted SDA pulse while SCL high; g=2: short SCL high pulse while SCL low
  task automatic send_bit(input logic v, input int g);
    msda = v; tick(Q); scl = 1'b1;
    if (g == 1) begin
      tick(Q/2); msda = ~v; tick(3); msda = v; tick(Q + Q/2 - 3);
    end else tick(2*Q);
    scl = 1'b0;
    if (g == 2) begin
      tick(4); scl = 1'b1; tick(3); scl = 1'b0; tick(Q - 7);
    end else tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic [7:0] g1, input logic [7:0] g2, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i], g1[i] ? 1 : g2[i] ? 2 : 0);
    msda = 1'b1; tick(Q); scl = 1'b1; tick(Q); ack = ~sda_bus; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic v);
    msda = 1'b1; tick(Q); scl = 1'b1; tick(Q); v = sda_bus; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      v[i] = x;
    end
    send_bit(nack, 0);
  endtask

  initial begin
    tick(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", host_rdata, 0);
    rstn = 1'b1;
    tick(10);

    start_c();
    send_byte(8'h72, 0, 0, a0);
    chk("wr_busy", busy, 1);
    send_byte(8'h10, 0, 0, a1);
    send_byte(8'hAB, 0, 0, a2);
    send_byte(8'hCD, 0, 0, a3);
    stop_c();
    chk("wr_ack_addr", a0, 1);
    chk("wr_ack_ptr", a1, 1);
    chk("wr_ack_d0", a2, 1);
    chk("wr_ack_d1", a3, 1);
    chk("wr_count", wv_cnt, 2);
    chk("wr0_addr", wa[0], 8'h10);
    chk("wr0_data", wd[0], 8'hAB);
    chk("wr1_addr", wa[1], 8'h11);
    chk("wr1_data", wd[1], 8'hCD);
    chk("wr_busy_after_stop", busy, 0);
    host_raddr = 8'h11; #1;
    chk("host_11", host_rdata, 8'hCD);
    host_raddr = 8'h10; #1;
    chk("host_10", host_rdata, 8'hAB);

    start_c();
    send_byte(8'h72, 0, 0, a0);
    send_byte(8'h10, 0, 0, a1);
    start_c();
    send_byte(8'h73, 0, 0, a2);
    recv_byte(1'b0, d1);
    recv_byte(1'b1, d2);
    chk("rd_oe_after_nack", sda_oe, 0);
    stop_c();
    chk("rd_ack_addr", a0, 1);
    chk("rd_ack_ptr", a1, 1);
    chk("rd_ack_raddr", a2, 1);
    chk("rd_byte0", d1, 8'hAB);
    chk("rd_byte1", d2, 8'hCD);
    chk("rd_busy_after_stop", busy, 0);
    chk("rd_no_write", wv_cnt, 2);

    oe0 = oe_cnt; busy0 = busy_cnt; wv0 = wv_cnt;
    start_c();
    send_byte(8'h74, 0, 0, a0);
    send_byte(8'h00, 0, 0, a1);
    stop_c();
    start_c();
    send_byte(8'h00, 0, 0, a2);
    send_byte(8'h55, 0, 0, a3);
    stop_c();
    chk("bad_ack_addr", a0, 0);
    chk("bad_ack_data", a1, 0);
    chk("gencall_ack", a2, 0);
    chk("gencall_ack_data", a3, 0);
    chk("bad_oe_never", oe_cnt, oe0);
    chk("bad_busy_never", busy_cnt, busy0);
    chk("bad_no_write", wv_cnt, wv0);

    start_c();
    send_byte(8'h72, 0, 0, a0);
    send_byte(8'hFF, 0, 0, a1);
    send_byte(8'h11, 0, 0, a2);
    send_byte(8'h22, 0, 0, a3);
    stop_c();
    chk("wrap_count", wv_cnt, 4);
    chk("wrap0_addr", wa[2], 8'hFF);
    chk("wrap0_data", wd[2], 8'h11);
    chk("wrap1_addr", wa[3], 8'h00);
    chk("wrap1_data", wd[3], 8'h22);
    host_raddr = 8'h00; #1;
    chk("host_00", host_rdata, 8'h22);
    start_c();
    send_byte(8'h72, 0, 0, a0);
    send_byte(8'hFF, 0, 0, a1);
    start_c();
    send_byte(8'h73, 0, 0, a2);
    recv_byte(1'b0, d1);
    recv_byte(1'b1, d2);
    stop_c();
    chk("rdwrap_byte0", d1, 8'h11);
    chk("rdwrap_byte1", d2, 8'h22);

    start_c();
    send_byte(8'h72, 0, 0, a0);
    send_byte(8'h20, 0, 0, a1);
    send_byte(8'h5A, 8'b0110_0000, 8'b0000_1000, a2);
    stop_c();
    chk("glitch_ack", a2, 1);
    chk("glitch_count", wv_cnt, 5);
    chk("glitch_addr", wa[4], 8'h20);
    chk("glitch_data", wd[4], 8'h5A);
    host_raddr = 8'h20; #1;
    chk("host_20", host_rdata, 8'h5A);

    start_c();
    send_byte(8'h72, 0, 0, a0);
    send_byte(8'h30, 0, 0, a1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    stop_c();
    chk("abort_no_write", wv_cnt, 5);
    chk("abort_busy", busy, 0);
    chk("abort_oe", sda_oe, 0);
    host_raddr = 8'h30; #1;
    chk("abort_host_30", host_rdata, 8'h00);

    start_c();
    send_byte(8'h72, 0, 0, a0);
    send_byte(8'h10, 0, 0, a1);
    start_c();
    send_byte(8'h73, 0, 0, a2);
    recv_bit(b);
    chk("rst_rd_bit7", b, 1);
    chk("rst_rd_oe_driving", sda_oe, 1);
    rstn = 1'b0;
    #1;
    chk("rst_rd_oe_async", sda_oe, 0);
    chk("rst_rd_busy_async", busy, 0);
    host_raddr = 8'h10; #1;
    chk("rst_rd_regs_cleared", host_rdata, 8'h00);
    tick(3);
    msda = 1'b1; scl = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
